// File: rtl/two_of_five_pkg.sv
// Shared constants and helpers for the two-out-of-five serial receiver.
// Code words are 5 bits, bit a (first on the wire) is the MSB.
package two_of_five_pkg;

  localparam int CODE_W  = 5;
  localparam int DIGIT_W = 4;

  localparam logic [CODE_W-1:0] CODE_0 = 5'b11000;
  localparam logic [CODE_W-1:0] CODE_1 = 5'b00011;
  localparam logic [CODE_W-1:0] CODE_2 = 5'b00101;
  localparam logic [CODE_W-1:0] CODE_3 = 5'b00110;
  localparam logic [CODE_W-1:0] CODE_4 = 5'b01001;
  localparam logic [CODE_W-1:0] CODE_5 = 5'b01010;
  localparam logic [CODE_W-1:0] CODE_6 = 5'b01100;
  localparam logic [CODE_W-1:0] CODE_7 = 5'b10001;
  localparam logic [CODE_W-1:0] CODE_8 = 5'b10010;
  localparam logic [CODE_W-1:0] CODE_9 = 5'b10100;

  // True when exactly two of the five bits are set.
  function automatic logic popcount2(input logic [CODE_W-1:0] w);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + {2'b00, w[i]};
    end
    return (ones == 3'd2);
  endfunction

endpackage

// File: rtl/two_of_five_decode.sv
// Combinational 2-of-5 word decoder: word -> {valid, digit}.
// Codes outside the table give valid=0 and digit=0.
module two_of_five_decode
  import two_of_five_pkg::*;
(
  input  logic [CODE_W-1:0]  i_word,
  output logic               o_valid,
  output logic [DIGIT_W-1:0] o_digit
);

  logic [DIGIT_W-1:0] w_digit;

  always_comb begin
    w_digit = 4'd0;
    case (i_word)
      CODE_0:  w_digit = 4'd0;
      CODE_1:  w_digit = 4'd1;
      CODE_2:  w_digit = 4'd2;
      CODE_3:  w_digit = 4'd3;
      CODE_4:  w_digit = 4'd4;
      CODE_5:  w_digit = 4'd5;
      CODE_6:  w_digit = 4'd6;
      CODE_7:  w_digit = 4'd7;
      CODE_8:  w_digit = 4'd8;
      CODE_9:  w_digit = 4'd9;
      default: w_digit = 4'd0;
    endcase
  end

  // The ten table entries are exactly the ten 5-bit words with two ones.
  assign o_valid = popcount2(i_word);
  assign o_digit = w_digit;

endmodule

// File: rtl/two_of_five_rx.sv
// Serial 2-of-5 digit receiver: deserializer, one pipeline stage, decoder,
// single-entry valid/ready holding buffer, overflow flag and error counter.
module two_of_five_rx
  import two_of_five_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  input  logic               digit_ready,
  output logic               code_err,
  output logic               overflow,
  output logic [ERR_W-1:0]   err_count
);

  logic [CODE_W-1:0]  r_shift;
  logic [2:0]         r_cnt;
  logic               r_word_done;
  logic [CODE_W-1:0]  r_word;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_digit_valid;
  logic               r_code_err;
  logic               r_overflow;
  logic [ERR_W-1:0]   r_err_count;

  logic [CODE_W-1:0]  w_shift_next;
  logic               w_dec_valid;
  logic [DIGIT_W-1:0] w_dec_digit;
  logic               w_xfer;
  logic               w_load;

  assign w_shift_next = {r_shift[CODE_W-2:0], bit_in};

  // Deserializer plus the word_done/word pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_cnt       <= 3'd0;
      r_word_done <= 1'b0;
      r_word      <= '0;
    end else if (clear) begin
      r_shift     <= '0;
      r_cnt       <= 3'd0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (bit_valid) begin
        r_shift <= w_shift_next;
        if (r_cnt == 3'd4) begin
          r_cnt       <= 3'd0;
          r_word      <= w_shift_next;
          r_word_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  two_of_five_decode u_decode (
    .i_word  (r_word),
    .o_valid (w_dec_valid),
    .o_digit (w_dec_digit)
  );

  assign w_xfer = r_digit_valid & digit_ready;
  // A draining buffer can accept a new digit in the same cycle.
  assign w_load = r_word_done & w_dec_valid & (~r_digit_valid | digit_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_code_err    <= 1'b0;
      r_overflow    <= 1'b0;
      r_err_count   <= '0;
    end else if (clear) begin
      r_digit_valid <= 1'b0;
      r_code_err    <= 1'b0;
      r_overflow    <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_code_err <= r_word_done & ~w_dec_valid;
      if (w_load) begin
        r_digit       <= w_dec_digit;
        r_digit_valid <= 1'b1;
      end else if (w_xfer) begin
        r_digit_valid <= 1'b0;
      end
      if (r_word_done & w_dec_valid & ~w_load) begin
        r_overflow <= 1'b1;
      end
      if (r_word_done & ~w_dec_valid & (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign code_err    = r_code_err;
  assign overflow    = r_overflow;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_two_of_five_rx.sv
// Self-checking bench for two_of_five_rx: directed scenarios with literal
// expectations plus a randomized run against a word-level behavioural model.
module tb_two_of_five_rx;

  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             bit_in;
  logic             bit_valid;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             digit_ready;
  logic             code_err;
  logic             overflow;
  logic [ERR_W-1:0] err_count;

  two_of_five_rx #(.ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .code_err    (code_err),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Code table indexed by digit, as plain integers (bit a = value 16).
  int code_tab [10] = '{24, 3, 5, 6, 9, 10, 12, 17, 18, 20};

  // Behavioural model state.
  int   m_nbits, m_acc, m_pword, m_digit, m_err;
  bit   m_pend, m_valid, m_ovf, m_cerr;

  function automatic int lookup(input int w);
    for (int d = 0; d < 10; d++) if (code_tab[d] == w) return d;
    return -1;
  endfunction

  task automatic model_reset();
    m_nbits = 0; m_acc = 0; m_pword = 0; m_pend = 0;
    m_digit = 0; m_valid = 0; m_ovf = 0; m_cerr = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit c, input bit bv, input bit b, input bit rdy);
    bit xfer;
    int d;
    m_cerr = 0;
    if (c) begin
      m_nbits = 0; m_acc = 0; m_pend = 0;
      m_valid = 0; m_ovf = 0; m_err = 0;
    end else begin
      xfer = m_valid && rdy;
      if (m_pend) begin
        d = lookup(m_pword);
        if (d >= 0) begin
          if (!m_valid || rdy) begin
            m_digit = d;
            m_valid = 1;
          end else begin
            m_ovf = 1;
          end
        end else begin
          m_cerr = 1;
          if (m_err < ERR_MAX) m_err++;
          if (xfer) m_valid = 0;
        end
      end else if (xfer) begin
        m_valid = 0;
      end
      m_pend = 0;
      if (bv) begin
        m_acc = (m_acc * 2 + int'(b)) % 32;
        m_nbits++;
        if (m_nbits == 5) begin
          m_pend  = 1;
          m_pword = m_acc;
          m_nbits = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("digit_valid", int'(digit_valid), int'(m_valid));
    check("code_err", int'(code_err), int'(m_cerr));
    check("overflow", int'(overflow), int'(m_ovf));
    check("err_count", int'(err_count), m_err);
    if (m_valid) check("digit", int'(digit), m_digit);
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input bit c, input bit bv, input bit b, input bit rdy);
    clear = c; bit_valid = bv; bit_in = b; digit_ready = rdy;
    @(posedge clk);
    model_edge(c, bv, b, rdy);
    #1;
    compare_model();
  endtask

  task automatic send_word(input int w, input bit rdy);
    for (int i = 4; i >= 0; i--) step(0, 1, bit'((w >> i) & 1), rdy);
    $display("word %05b sent (ready=%0d)", w[4:0], rdy);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, rdy);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; digit_ready = 1'b0;
    model_reset();
    #6;
    check("rst digit", int'(digit), 0);
    check("rst digit_valid", int'(digit_valid), 0);
    check("rst code_err", int'(code_err), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst err_count", int'(err_count), 0);
    #6 rst_n = 1'b1;

    // Code 01010 -> digit 5, visible one cycle after the 5th bit, then drained.
    send_word(5'b01010, 1);
    check("d5 before", int'(digit_valid), 0);
    idle(1);
    check("d5 valid", int'(digit_valid), 1);
    check("d5 digit", int'(digit), 5);
    check("d5 err_count", int'(err_count), 0);
    idle(1);
    check("d5 drained", int'(digit_valid), 0);

    // Invalid 11100 then 11000 -> digit 0.
    send_word(5'b11100, 1);
    idle(1);
    check("inv code_err", int'(code_err), 1);
    check("inv err_count", int'(err_count), 1);
    check("inv digit_valid", int'(digit_valid), 0);
    idle(1);
    check("inv pulse end", int'(code_err), 0);
    send_word(5'b11000, 1);
    idle(1);
    check("d0 digit", int'(digit), 0);
    check("d0 valid", int'(digit_valid), 1);
    idle(1);

    // Backpressure: 00011 held, 10100 dropped with overflow.
    send_word(5'b00011, 0);
    send_word(5'b10100, 0);
    idle(0);
    check("ovf digit held", int'(digit), 1);
    check("ovf valid", int'(digit_valid), 1);
    check("ovf flag", int'(overflow), 1);
    idle(1);
    check("ovf drained", int'(digit_valid), 0);
    check("ovf sticky", int'(overflow), 1);

    // Clear, then all ten codes back-to-back with ready held high.
    step(1, 0, 0, 1);
    check("clr overflow", int'(overflow), 0);
    check("clr err_count", int'(err_count), 0);
    for (int k = 0; k < 10; k++) begin
      w = code_tab[k];
      for (int i = 4; i >= 0; i--) begin
        step(0, 1, bit'((w >> i) & 1), 1);
        if (k > 0 && i == 4) begin
          check("stream valid", int'(digit_valid), 1);
          check("stream digit", int'(digit), k - 1);
        end
      end
    end
    idle(1);
    check("stream last", int'(digit), 9);
    check("stream no ovf", int'(overflow), 0);
    idle(1);

    // Partial word and the bit in the clear cycle are discarded.
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    send_word(5'b00110, 1);
    idle(1);
    check("resync digit", int'(digit), 3);
    check("resync valid", int'(digit_valid), 1);
    check("resync err", int'(err_count), 0);
    idle(1);

    // Five invalid words: err_count saturates at 3, five code_err pulses.
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
        send_word(5'b00000, 1);
        idle(1);
        pulses += int'(code_err);
      end
      check("sat pulses", pulses, 5);
      check("sat err_count", int'(err_count), 3);
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    $display("random run done, %0d compared so far", n_cmp);

    // Asynchronous reset mid-word with non-zero outputs.
    step(1, 0, 0, 0);
    send_word(5'b00011, 0);
    idle(0);
    send_word(5'b00000, 0);
    send_word(5'b10100, 0);
    idle(0);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst digit", int'(digit), 0);
    check("arst digit_valid", int'(digit_valid), 0);
    check("arst overflow", int'(overflow), 0);
    check("arst err_count", int'(err_count), 0);
    check("arst code_err", int'(code_err), 0);
    model_reset();
    #3 rst_n = 1'b1;
    send_word(5'b01100, 1);
    idle(1);
    check("post-rst digit", int'(digit), 6);
    check("post-rst valid", int'(digit_valid), 1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
